// File: rtl/fifo_rd_serializer.sv
// Pops wide words from a show-ahead FIFO and streams them out as narrow slices on valid/ready.
// Optional build macro FIFO_RD_SER_MSB_FIRST_EN emits the most significant slice first.
module fifo_rd_serializer #(
  parameter int IN_W   = 32,
  parameter int OUT_W  = 8,
  parameter int SLICES = IN_W / OUT_W,
  parameter int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             fifo_empty,
  output logic             fifo_rd,
  input  logic [IN_W-1:0]  fifo_q,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic             m_last,
  output logic             busy
);

  localparam logic [0:0]       ST_EMPTY = 1'b0;
  localparam logic [0:0]       ST_HOLD  = 1'b1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IN_W-1:0]  word_q, word_d;
  logic             transfer_s, last_take_s, load_s;

  function automatic logic [OUT_W-1:0] pick_slice(input logic [IN_W-1:0] w,
                                                  input logic [IDX_W-1:0] i);
    logic [OUT_W-1:0] r;
    r = {OUT_W{1'b0}};
    for (int s = 0; s < SLICES; s++) begin
      if (i == IDX_W'(s)) begin
`ifdef FIFO_RD_SER_MSB_FIRST_EN
        r = w[(SLICES-1-s)*OUT_W +: OUT_W];
`else
        r = w[s*OUT_W +: OUT_W];
`endif
      end
    end
    return r;
  endfunction

  // Handshake decode; the pop is gated by rstn so nothing is consumed while in reset.
  always_comb begin
    transfer_s  = (state_q == ST_HOLD) && m_ready;
    last_take_s = transfer_s && (idx_q == LAST_IDX);
    load_s      = rstn && !fifo_empty && ((state_q == ST_EMPTY) || last_take_s);
  end

  // Next-state: a load on the final slice keeps the stream gap-free.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    if (load_s) begin
      word_d  = fifo_q;
      idx_d   = {IDX_W{1'b0}};
      state_d = ST_HOLD;
    end else if (last_take_s) begin
      state_d = ST_EMPTY;
      idx_d   = {IDX_W{1'b0}};
    end else if (transfer_s) begin
      idx_d = idx_q + IDX_W'(1);
    end else begin
      state_d = state_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_EMPTY;
      idx_q   <= {IDX_W{1'b0}};
      word_q  <= {IN_W{1'b0}};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
    end
  end

  assign fifo_rd = load_s;
  assign m_valid = (state_q == ST_HOLD);
  assign busy    = (state_q == ST_HOLD);
  assign m_last  = (state_q == ST_HOLD) && (idx_q == LAST_IDX);
  assign m_data  = pick_slice(word_q, idx_q);

endmodule

// File: tb/tb_fifo_rd_serializer.sv
// Self-checking bench for fifo_rd_serializer (IN_W=32, OUT_W=8) with a queue-based reference model.
module tb_fifo_rd_serializer;

  logic        clk;
  logic        rstn;
  logic        fifo_empty;
  logic        fifo_rd;
  logic [31:0] fifo_q;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        m_last;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] fq[$];
  logic [7:0]  cur[$];
  logic [7:0]  acc[$];
  logic        acc_rd[$];

  fifo_rd_serializer #(.IN_W(32), .OUT_W(8)) dut (
    .clk(clk), .rstn(rstn), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd), .fifo_q(fifo_q),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a popped word becomes a list of slices in emission order.
  function automatic void load_cur(input logic [31:0] w);
    cur.delete();
    for (int s = 0; s < 4; s++) begin
`ifdef FIFO_RD_SER_MSB_FIRST_EN
      cur.push_back(w[(3-s)*8 +: 8]);
`else
      cur.push_back(w[s*8 +: 8]);
`endif
    end
  endfunction

  task automatic step(input logic rdy);
    logic exp_v, exp_rd, xfer;
    m_ready    = rdy;
    fifo_empty = (fq.size() == 0);
    fifo_q     = fifo_empty ? $urandom() : fq[0];
    #1;
    exp_v  = (cur.size() != 0);
    xfer   = exp_v && rdy;
    exp_rd = !fifo_empty && (!exp_v || (xfer && cur.size() == 1));
    checks++;
    if (fifo_rd !== exp_rd) begin errors++; $display("FAIL fifo_rd got %b exp %b", fifo_rd, exp_rd); end
    checks++;
    if (m_valid !== exp_v) begin errors++; $display("FAIL m_valid got %b exp %b", m_valid, exp_v); end
    checks++;
    if (busy !== exp_v) begin errors++; $display("FAIL busy got %b exp %b", busy, exp_v); end
    checks++;
    if (m_last !== (exp_v && cur.size() == 1)) begin
      errors++; $display("FAIL m_last got %b exp %b", m_last, exp_v && cur.size() == 1);
    end
    if (exp_v) begin
      checks++;
      if (m_data !== cur[0]) begin errors++; $display("FAIL m_data got %h exp %h", m_data, cur[0]); end
    end
    if (xfer) begin
      acc.push_back(m_data);
      acc_rd.push_back(fifo_rd);
      void'(cur.pop_front());
    end
    if (exp_rd) begin
      load_cur(fq[0]);
      void'(fq.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0; m_ready = 1'b1; fifo_empty = 1'b0; fifo_q = 32'h1234_5678;
    repeat (3) @(negedge clk);
    checks++;
    if (fifo_rd !== 1'b0) begin errors++; $display("FAIL rst_fifo_rd got %b exp 0", fifo_rd); end
    checks++;
    if ({m_valid, busy, m_last} !== 3'b000) begin
      errors++; $display("FAIL rst_flags got %b exp 000", {m_valid, busy, m_last});
    end
    checks++;
    if (m_data !== 8'h00) begin errors++; $display("FAIL rst_m_data got %h exp 00", m_data); end
    fifo_empty = 1'b1;
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_word();
    logic [7:0] e[4];
`ifdef FIFO_RD_SER_MSB_FIRST_EN
    e = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
`else
    e = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
`endif
    acc.delete(); acc_rd.delete();
    fq.push_back(32'hA1B2_C3D4);
    repeat (6) step(1'b1);
    checks++;
    if (acc.size() != 4) begin errors++; $display("FAIL single_count got %0d exp 4", acc.size()); end
    for (int i = 0; i < 4 && i < acc.size(); i++) begin
      checks++;
      if (acc[i] !== e[i]) begin errors++; $display("FAIL single_beat%0d got %h exp %h", i, acc[i], e[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e[8];
`ifdef FIFO_RD_SER_MSB_FIRST_EN
    e = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
`else
    e = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
`endif
    acc.delete(); acc_rd.delete();
    fq.push_back(32'h1122_3344);
    fq.push_back(32'h5566_7788);
    step(1'b1);
    repeat (8) step(1'b1);
    checks++;
    if (acc.size() != 8) begin errors++; $display("FAIL b2b_count got %0d exp 8", acc.size()); end
    for (int i = 0; i < 8 && i < acc.size(); i++) begin
      checks++;
      if (acc[i] !== e[i]) begin errors++; $display("FAIL b2b_beat%0d got %h exp %h", i, acc[i], e[i]); end
    end
    if (acc_rd.size() > 3) begin
      checks++;
      if (acc_rd[3] !== 1'b1) begin errors++; $display("FAIL b2b_pop_on_last got %b exp 1", acc_rd[3]); end
    end
    step(1'b1);
  endtask

  task automatic test_backpressure();
    logic [7:0] held;
`ifdef FIFO_RD_SER_MSB_FIRST_EN
    held = 8'hB2;
`else
    held = 8'hC3;
`endif
    acc.delete(); acc_rd.delete();
    fq.push_back(32'hA1B2_C3D4);
    step(1'b1);
    step(1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      checks++;
      if (m_data !== held) begin errors++; $display("FAIL bp_hold%0d got %h exp %h", i, m_data, held); end
    end
    repeat (4) step(1'b1);
    checks++;
    if (acc.size() != 4) begin errors++; $display("FAIL bp_count got %0d exp 4", acc.size()); end
  endtask

  task automatic test_underflow();
    acc.delete();
    repeat (5) step(1'b1);
    fq.push_back(32'h0BAD_F00D);
    step(1'b1);
    checks++;
    if (m_valid !== 1'b1) begin errors++; $display("FAIL uf_latency got %b exp 1", m_valid); end
    repeat (5) step(1'b1);
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] e[4];
`ifdef FIFO_RD_SER_MSB_FIRST_EN
    e = '{8'hCA, 8'hFE, 8'hBA, 8'hBE};
`else
    e = '{8'hBE, 8'hBA, 8'hFE, 8'hCA};
`endif
    fq.push_back(32'hA1B2_C3D4);
    step(1'b1);
    step(1'b1);
    fifo_empty = 1'b0; fifo_q = 32'h5A5A_5A5A; m_ready = 1'b1;
    rstn = 1'b0;
    #1;
    checks++;
    if ({m_valid, busy, m_last, fifo_rd} !== 4'b0000) begin
      errors++; $display("FAIL mid_rst_flags got %b exp 0000", {m_valid, busy, m_last, fifo_rd});
    end
    checks++;
    if (m_data !== 8'h00) begin errors++; $display("FAIL mid_rst_m_data got %h exp 00", m_data); end
    cur.delete(); fq.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (3) step(1'b1);
    acc.delete();
    fq.push_back(32'hCAFE_BABE);
    repeat (6) step(1'b1);
    checks++;
    if (acc.size() != 4) begin errors++; $display("FAIL rst_word_count got %0d exp 4", acc.size()); end
    for (int i = 0; i < 4 && i < acc.size(); i++) begin
      checks++;
      if (acc[i] !== e[i]) begin errors++; $display("FAIL rst_word_beat%0d got %h exp %h", i, acc[i], e[i]); end
    end
  endtask

  task automatic test_random();
    int budget;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 99) < 40 && fq.size() < 8) fq.push_back($urandom());
      step($urandom_range(0, 99) < 70);
    end
    budget = 100;
    while ((cur.size() != 0 || fq.size() != 0) && budget > 0) begin
      step(1'b1);
      budget--;
    end
    checks++;
    if (budget == 0) begin errors++; $display("FAIL rand_drain got pending exp drained"); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_underflow();
    test_reset_mid_word();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
